// File: rtl/riva_pkg.sv
// Shared types for the VLSU transaction fragmenter.
// Request and txn bundles plus the fragmenter FSM encoding.
package riva_pkg;

  localparam int unsigned FragAddrW    = 64;
  localparam int unsigned FragSegBytesW = 20;
  localparam int unsigned FragNrSegW   = 16;
  localparam int unsigned FragIdW      = 4;
  localparam int unsigned FragPageB    = 4096;
  localparam int unsigned FragMaxTxnB  = 1024;
  localparam int unsigned FragQDepth   = 2;
  localparam int unsigned FragTxnBW    = $clog2(FragMaxTxnB) + 1;

  typedef struct packed {
    logic [FragIdW-1:0]       id;
    logic [FragAddrW-1:0]     addr;
    logic [FragSegBytesW-1:0] seg_bytes;
    logic [FragAddrW-1:0]     stride;
    logic [FragNrSegW-1:0]    nr_seg;
  } frag_req_t;

  typedef struct packed {
    logic [FragIdW-1:0]   id;
    logic [FragAddrW-1:0] addr;
    logic [FragTxnBW-1:0] bytes;
    logic                 first;
    logic                 last_seg;
    logic                 last;
  } frag_txn_t;

  typedef enum logic [1:0] {
    FragIdle  = 2'd0,
    FragLoad  = 2'd1,
    FragStall = 2'd2,
    FragEmit  = 2'd3
  } frag_state_e;

endpackage

// File: rtl/frag_req_queue.sv
// Small request FIFO in front of the fragmenter.
// Push and pop may coincide, including when full.
module frag_req_queue
  import riva_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      i_push,
  input  frag_req_t i_req,
  input  logic      i_pop,
  output frag_req_t o_req,
  output logic      o_full,
  output logic      o_empty
);

  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);

  frag_req_t        r_mem [Depth];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == CW'(Depth));
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_req   = r_mem[r_rd];

  // Storage needs no reset; only occupied slots are ever read.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= i_req;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wr <= (r_wr == PW'(Depth - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop)
        r_rd <= (r_rd == PW'(Depth - 1)) ? '0 : r_rd + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/vlsu_txn_fragmenter.sv
// Splits strided VLSU requests into bus txns that never
// cross a MaxTxnBytes-aligned boundary.
module vlsu_txn_fragmenter
  import riva_pkg::*;
#(
  parameter int unsigned AddrWidth   = FragAddrW,
  parameter int unsigned SegBytesW   = FragSegBytesW,
  parameter int unsigned NrSegW      = FragNrSegW,
  parameter int unsigned IdWidth     = FragIdW,
  parameter int unsigned PageBytes   = FragPageB,
  parameter int unsigned MaxTxnBytes = FragMaxTxnB,
  parameter int unsigned ReqQDepth   = FragQDepth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [IdWidth-1:0]     req_id_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [SegBytesW-1:0]   req_seg_bytes_i,
  input  logic [AddrWidth-1:0]   req_stride_i,
  input  logic [NrSegW-1:0]      req_nr_seg_i,
  input  logic                   stall_i,
  output logic                   txn_valid_o,
  input  logic                   txn_ready_i,
  output logic [IdWidth-1:0]     txn_id_o,
  output logic [AddrWidth-1:0]   txn_addr_o,
  output logic [$clog2(MaxTxnBytes):0] txn_bytes_o,
  output logic                   txn_first_o,
  output logic                   txn_last_seg_o,
  output logic                   txn_last_o,
  output logic                   busy_o
);

  localparam int unsigned LW = $clog2(MaxTxnBytes);
  localparam int unsigned TW = LW + 1;

  if (MaxTxnBytes > PageBytes) begin : g_chk_txn
    $error("MaxTxnBytes must not exceed PageBytes");
  end
  if (AddrWidth != FragAddrW || SegBytesW != FragSegBytesW ||
      NrSegW != FragNrSegW || IdWidth != FragIdW) begin : g_chk_w
    $error("widths must match riva_pkg bundle widths");
  end
  if (ReqQDepth < 1) begin : g_chk_q
    $error("ReqQDepth must be at least 1");
  end

  frag_state_e            r_state;
  frag_state_e            w_state_d;
  logic [IdWidth-1:0]     r_id;
  logic [AddrWidth-1:0]   r_addr;
  logic [AddrWidth-1:0]   r_seg_base;
  logic [AddrWidth-1:0]   r_stride;
  logic [SegBytesW-1:0]   r_seg_bytes;
  logic [SegBytesW-1:0]   r_rmn_bytes;
  logic [NrSegW-1:0]      r_rmn_seg;
  logic                   r_first;

  frag_req_t              w_push_req;
  frag_req_t              w_pop_req;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_pop_ok;
  logic                   w_full;
  logic                   w_empty;
  logic [TW-1:0]          w_bnd;
  logic [TW-1:0]          w_txn_bytes;
  logic                   w_last_seg;
  logic                   w_last;
  logic                   w_hs;
  logic [AddrWidth-1:0]   w_add_a;
  logic [AddrWidth-1:0]   w_add_b;
  logic [AddrWidth-1:0]   w_sum;

  assign w_push_req = '{
    id:        req_id_i,
    addr:      req_addr_i,
    seg_bytes: req_seg_bytes_i,
    stride:    req_stride_i,
    nr_seg:    req_nr_seg_i
  };
  assign req_ready_o = !w_full;
  assign w_push      = req_valid_i && !w_full;

  frag_req_queue #(
    .Depth (ReqQDepth)
  ) u_req_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_push),
    .i_req   (w_push_req),
    .i_pop   (w_pop),
    .o_req   (w_pop_req),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_bnd       = TW'(MaxTxnBytes) - {1'b0, r_addr[LW-1:0]};
  assign w_last_seg  = (r_rmn_bytes <= SegBytesW'(w_bnd));
  assign w_txn_bytes = w_last_seg ? r_rmn_bytes[TW-1:0] : w_bnd;
  assign w_last      = w_last_seg && (r_rmn_seg == '0);
  assign w_hs        = (r_state == FragEmit) && txn_ready_i;

  // One adder serves both the in-segment step and the stride hop.
  assign w_add_a = w_last_seg ? r_seg_base : r_addr;
  assign w_add_b = w_last_seg ? r_stride : AddrWidth'(w_txn_bytes);
  assign w_sum   = w_add_a + w_add_b;

  // Empty requests are popped and silently dropped.
  assign w_pop_ok = (w_pop_req.seg_bytes != '0) &&
                    (w_pop_req.nr_seg != '0);
  assign w_pop    = !w_empty &&
                    ((r_state == FragIdle) || (w_hs && w_last));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= FragIdle;
    else         r_state <= w_state_d;
  end

  // Next-state logic; stall is only honoured before EMIT.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      FragIdle:
        if (w_pop && w_pop_ok) w_state_d = FragLoad;
      FragLoad, FragStall:
        w_state_d = stall_i ? FragStall : FragEmit;
      FragEmit:
        if (w_hs && w_last)
          w_state_d = (w_pop && w_pop_ok) ? FragLoad : FragIdle;
      default:
        w_state_d = FragIdle;
    endcase
  end

  // Working registers: load on pop, advance on handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id        <= '0;
      r_addr      <= '0;
      r_seg_base  <= '0;
      r_stride    <= '0;
      r_seg_bytes <= '0;
      r_rmn_bytes <= '0;
      r_rmn_seg   <= '0;
      r_first     <= 1'b0;
    end else if (w_pop) begin
      r_id        <= w_pop_req.id;
      r_addr      <= w_pop_req.addr;
      r_seg_base  <= w_pop_req.addr;
      r_stride    <= w_pop_req.stride;
      r_seg_bytes <= w_pop_req.seg_bytes;
      r_rmn_bytes <= w_pop_req.seg_bytes;
      r_rmn_seg   <= w_pop_req.nr_seg - 1'b1;
      r_first     <= 1'b1;
    end else if (w_hs) begin
      r_first <= 1'b0;
      if (!w_last_seg) begin
        r_addr      <= w_sum;
        r_rmn_bytes <= r_rmn_bytes - SegBytesW'(w_txn_bytes);
      end else begin
        r_seg_base  <= w_sum;
        r_addr      <= w_sum;
        r_rmn_bytes <= r_seg_bytes;
        r_rmn_seg   <= r_rmn_seg - 1'b1;
      end
    end
  end

  // Txn outputs are driven only in EMIT, from registered state.
  always_comb begin
    txn_valid_o    = 1'b0;
    txn_id_o       = '0;
    txn_addr_o     = '0;
    txn_bytes_o    = '0;
    txn_first_o    = 1'b0;
    txn_last_seg_o = 1'b0;
    txn_last_o     = 1'b0;
    if (r_state == FragEmit) begin
      txn_valid_o    = 1'b1;
      txn_id_o       = r_id;
      txn_addr_o     = r_addr;
      txn_bytes_o    = w_txn_bytes;
      txn_first_o    = r_first;
      txn_last_seg_o = w_last_seg;
      txn_last_o     = w_last;
    end
  end

  assign busy_o = !w_empty || (r_state != FragIdle);

endmodule
